mult2_accum: RTL and testbench

Sequential operand feeder and product accumulator wrapped around the combinational 2-bit multiplier `Multi2`. Accepts a stream of 2-bit operand pairs over a valid/ready handshake, registers each pair onto the multiplier inputs, and captures the 4-bit product one cycle later. Sums `COUNT` consecutive products into an `ACC_W`-bit accumulator and presents the total on a valid/ready output port. Sits directly upstream (drives `a0,a1,b0,b1`) and downstream (consumes `m0..m3`) of the multiplier instance.

---
 rtl/mult2_accum.sv | 116 +++++++++++
 tb/tb_mult2_accum.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult2_accum.sv
// Operand feeder and product accumulator around an external combinational
// 2x2 multiplier: registers each accepted pair, sums COUNT products, hands off the total.
module mult2_accum #(
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_a,
   input  logic [1:0]       in_b,
   output logic             mul_a0,
   output logic             mul_a1,
   output logic             mul_b0,
   output logic             mul_b1,
   input  logic             mul_m0,
   input  logic             mul_m1,
   input  logic             mul_m2,
   input  logic             mul_m3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf
);

   typedef enum logic {ST_ACC = 1'b0, ST_DONE = 1'b1} state_t;

   localparam logic [3:0] COUNT_L = 4'(COUNT);

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_op_a;
   logic [1:0]       r_op_b;
   logic             r_pend;
   logic [3:0]       r_issued;
   logic [3:0]       r_done_cnt;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;

   logic             w_accept;
   logic             w_release;
   logic             w_last;
   logic [3:0]       w_prod;
   logic [ACC_W:0]   w_sum;

   assign w_prod    = {mul_m3, mul_m2, mul_m1, mul_m0};
   // Extra top bit of the sum is the carry that feeds the sticky overflow flag.
   assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 3){1'b0}}, w_prod};
   assign w_accept  = in_valid && in_ready;
   assign w_release = out_valid && out_ready;
   assign w_last    = r_pend && ((r_done_cnt + 4'd1) == COUNT_L);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; combinational blocks use blocking with defaults.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ACC;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (r_state == ST_ACC) begin
         if (w_last) w_next = ST_DONE;
      end else begin
         if (out_ready) w_next = ST_ACC;
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (r_state == ST_ACC) in_ready  = (r_issued < COUNT_L);
      else                   out_valid = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_pend     <= 1'b0;
         r_issued   <= '0;
         r_done_cnt <= '0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
      end else if (w_release) begin
         r_pend     <= 1'b0;
         r_issued   <= '0;
         r_done_cnt <= '0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
      end else begin
         // Accept and accumulate may coincide: the add uses the product of the
         // pair already sitting in the operand registers.
         r_pend <= w_accept;
         if (w_accept) begin
            r_op_a   <= in_a;
            r_op_b   <= in_b;
            r_issued <= r_issued + 4'd1;
         end
         if (r_pend) begin
            r_acc      <= w_sum[ACC_W-1:0];
            r_ovf      <= r_ovf | w_sum[ACC_W];
            r_done_cnt <= r_done_cnt + 4'd1;
         end
      end
   end

   assign mul_a0  = r_op_a[0];
   assign mul_a1  = r_op_a[1];
   assign mul_b0  = r_op_b[0];
   assign mul_b1  = r_op_b[1];
   assign out_acc = r_acc;
   assign out_ovf = r_ovf;

endmodule

// File: tb/tb_mult2_accum.sv
// Scoreboard bench for mult2_accum: two instances (8-bit/4 products and
// 4-bit/2 products) each wrapped around a behavioural 2x2 multiplier.
module tb_mult2_accum;

   typedef struct {
      logic [15:0] acc;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   // Per-instance stimulus/response signals: index 0 = main, 1 = narrow
   logic       in_valid  [2];
   logic [1:0] in_a      [2];
   logic [1:0] in_b      [2];
   logic       out_ready [2];
   logic       in_ready  [2];
   logic       out_valid [2];
   logic       out_ovf   [2];
   logic       ma0 [2], ma1 [2], mb0 [2], mb1 [2];
   logic [3:0] mm  [2];
   logic [7:0] acc_a;
   logic [3:0] acc_b;

   assign mm[0] = {2'b00, ma1[0], ma0[0]} * {2'b00, mb1[0], mb0[0]};
   assign mm[1] = {2'b00, ma1[1], ma0[1]} * {2'b00, mb1[1], mb0[1]};

   mult2_accum #(.ACC_W(8), .COUNT(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]),
      .mul_a0(ma0[0]), .mul_a1(ma1[0]), .mul_b0(mb0[0]), .mul_b1(mb1[0]),
      .mul_m0(mm[0][0]), .mul_m1(mm[0][1]), .mul_m2(mm[0][2]), .mul_m3(mm[0][3]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_acc(acc_a), .out_ovf(out_ovf[0])
   );

   mult2_accum #(.ACC_W(4), .COUNT(2)) u_narrow (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1]), .in_b(in_b[1]),
      .mul_a0(ma0[1]), .mul_a1(ma1[1]), .mul_b0(mb0[1]), .mul_b1(mb1[1]),
      .mul_m0(mm[1][0]), .mul_m1(mm[1][1]), .mul_m2(mm[1][2]), .mul_m3(mm[1][3]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_acc(acc_b), .out_ovf(out_ovf[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: pop and compare on every output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid[0] && out_ready[0]) begin
         if (q_a.size() == 0) check("main_unexpected_result", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q_a.pop_front();
            check("main_out_acc", {24'd0, acc_a}, {16'd0, e.acc});
            check("main_out_ovf", {31'd0, out_ovf[0]}, {31'd0, e.ovf});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid[1] && out_ready[1]) begin
         if (q_b.size() == 0) check("narrow_unexpected_result", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q_b.pop_front();
            check("narrow_out_acc", {28'd0, acc_b}, {16'd0, e.acc});
            check("narrow_out_ovf", {31'd0, out_ovf[1]}, {31'd0, e.ovf});
         end
      end
   end

   // Present one pair, wait (bounded) for in_ready, hold it through the accept edge
   task automatic send(input int s, input logic [1:0] a, input logic [1:0] b, input int gap);
      int cnt;
      in_a[s] = a;
      in_b[s] = b;
      in_valid[s] = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (!in_ready[s] && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (!in_ready[s]) check("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      in_valid[s] = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int s, input logic [15:0] acc, input logic ovf);
      exp_t e;
      e.acc = acc;
      e.ovf = ovf;
      if (s == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   task automatic drain(input int s);
      int cnt;
      cnt = 0;
      while (((s == 0) ? q_a.size() : q_b.size()) != 0 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("drain_pending", 32'((s == 0) ? q_a.size() : q_b.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 1'b0;
         in_a[s]      = 2'd0;
         in_b[s]      = 2'd0;
         out_ready[s] = 1'b1;
      end

      // Reset state
      #3;
      check("rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
      check("rst_out_acc", {24'd0, acc_a}, 32'd0);
      check("rst_out_ovf", {31'd0, out_ovf[0]}, 32'd0);
      check("rst_mul_ops", {28'd0, ma1[0], ma0[0], mb1[0], mb0[0]}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Operand drive: (2,1) lands on the multiplier, product 2 added next edge, once
      push(0, 16'd6, 1'b0);
      send(0, 2'd2, 2'd1, 0);
      check("drive_mul_a1", {31'd0, ma1[0]}, 32'd1);
      check("drive_mul_a0", {31'd0, ma0[0]}, 32'd0);
      check("drive_mul_b1", {31'd0, mb1[0]}, 32'd0);
      check("drive_mul_b0", {31'd0, mb0[0]}, 32'd1);
      @(posedge clk);
      #1;
      check("drive_acc_after_add", {24'd0, acc_a}, 32'd2);
      @(posedge clk);
      #1;
      check("drive_acc_no_double_add", {24'd0, acc_a}, 32'd2);
      send(0, 2'd1, 2'd1, 0);
      send(0, 2'd0, 2'd3, 0);
      send(0, 2'd3, 2'd1, 0);
      drain(0);

      // Back-to-back: 1 + 6 + 6 + 9 = 22
      push(0, 16'd22, 1'b0);
      send(0, 2'd1, 2'd1, 0);
      send(0, 2'd2, 2'd3, 0);
      send(0, 2'd3, 2'd2, 0);
      send(0, 2'd3, 2'd3, 0);
      check("b2b_in_ready_low", {31'd0, in_ready[0]}, 32'd0);
      check("b2b_out_valid_not_yet", {31'd0, out_valid[0]}, 32'd0);
      @(posedge clk);
      #1;
      check("b2b_out_valid_rise", {31'd0, out_valid[0]}, 32'd1);
      check("b2b_in_ready_still_low", {31'd0, in_ready[0]}, 32'd0);
      drain(0);
      check("b2b_in_ready_after", {31'd0, in_ready[0]}, 32'd1);

      // Gapped input, same pairs
      push(0, 16'd22, 1'b0);
      send(0, 2'd1, 2'd1, 2);
      send(0, 2'd2, 2'd3, 2);
      send(0, 2'd3, 2'd2, 2);
      send(0, 2'd3, 2'd3, 2);
      drain(0);

      // Backpressure: 3 + 4 + 9 + 0 = 16 held for 5 cycles
      out_ready[0] = 1'b0;
      push(0, 16'd16, 1'b0);
      send(0, 2'd1, 2'd3, 0);
      send(0, 2'd2, 2'd2, 0);
      send(0, 2'd3, 2'd3, 0);
      send(0, 2'd0, 2'd1, 0);
      cnt = 0;
      while (!out_valid[0] && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("bp_out_valid_seen", {31'd0, out_valid[0]}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("bp_acc_stable", {24'd0, acc_a}, 32'd16);
         check("bp_in_ready_low", {31'd0, in_ready[0]}, 32'd0);
         check("bp_out_valid_held", {31'd0, out_valid[0]}, 32'd1);
      end
      @(posedge clk);
      #1 out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_valid_cleared", {31'd0, out_valid[0]}, 32'd0);
      check("bp_in_ready_back", {31'd0, in_ready[0]}, 32'd1);
      check("bp_acc_cleared", {24'd0, acc_a}, 32'd0);
      check("bp_queue_empty", 32'(q_a.size()), 32'd0);

      // Overflow on the narrow instance: 9 + 9 = 18 -> 2 with ovf; then 1 + 0 = 1
      push(1, 16'd2, 1'b1);
      send(1, 2'd3, 2'd3, 0);
      send(1, 2'd3, 2'd3, 0);
      drain(1);
      push(1, 16'd1, 1'b0);
      send(1, 2'd1, 2'd1, 0);
      send(1, 2'd0, 2'd2, 0);
      drain(1);

      // Reset mid-group: everything clears asynchronously, no partial result
      send(0, 2'd1, 2'd1, 0);
      send(0, 2'd2, 2'd2, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_acc", {24'd0, acc_a}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready[0]}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid[0]}, 32'd0);
      check("midrst_mul_ops", {28'd0, ma1[0], ma0[0], mb1[0], mb0[0]}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(0, 16'd36, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 2'd3, 2'd3, 0);
      drain(0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
